// File: rtl/mem_pkg.sv
// Shared definitions for the tile memory-port arbiter: op encodings, FSM states
// and the load-extraction / store-lane helpers.
package mem_pkg;

  localparam logic [2:0] OP_LB  = 3'b000;
  localparam logic [2:0] OP_LH  = 3'b001;
  localparam logic [2:0] OP_LW  = 3'b010;
  localparam logic [2:0] OP_LBU = 3'b100;
  localparam logic [2:0] OP_LHU = 3'b101;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam int TIMEOUT_DEF = 255;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  function automatic logic [31:0] load_extract(input logic [2:0]  op,
                                               input logic [1:0]  lane,
                                               input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[8*lane +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (op)
      OP_LB:   load_extract = {{24{b[7]}}, b};
      OP_LBU:  load_extract = {24'h0, b};
      OP_LH:   load_extract = {{16{h[15]}}, h};
      OP_LHU:  load_extract = {16'h0, h};
      OP_LW:   load_extract = word;
      default: load_extract = 32'h0;
    endcase
  endfunction

  function automatic logic [3:0] store_strb(input logic [1:0] size,
                                            input logic [1:0] lane);
    case (size)
      SZ_B:    store_strb = 4'b0001 << lane;
      SZ_H:    store_strb = lane[1] ? 4'b1100 : 4'b0011;
      SZ_W:    store_strb = 4'b1111;
      default: store_strb = 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [1:0]  size,
                                             input logic [31:0] wdata);
    case (size)
      SZ_B:    store_data = {4{wdata[7:0]}};
      SZ_H:    store_data = {2{wdata[15:0]}};
      default: store_data = wdata;
    endcase
  endfunction

  // Loads and stores share size in op[1:0]; anything that would need a
  // memory access we cannot express correctly is rejected up front.
  function automatic logic access_bad(input logic       write,
                                      input logic [2:0] op,
                                      input logic [1:0] lane);
    if (!write && (op == 3'b011 || op == 3'b110 || op == 3'b111)) return 1'b1;
    if (write && op[1:0] == 2'b11) return 1'b1;
    case (op[1:0])
      SZ_H:    return lane[0];
      SZ_W:    return lane != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first valid requester at or after i_ptr.
module rr_arbiter
  import mem_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] i_valid,
  input  logic [IW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_grant,
  output logic [IW-1:0]   o_idx,
  output logic            o_any
);

  int w_j;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_j     = 0;
    for (int k = 0; k < NREQ; k++) begin
      w_j = (int'(i_ptr) + k) % NREQ;
      if (!o_any && i_valid[w_j]) begin
        o_any        = 1'b1;
        o_idx        = w_j[IW-1:0];
        o_grant[w_j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin sharing of the tile memory port; one response per accepted request.
// State | meaning: IDLE wait/grant, ISSUE strobe held until ack/timeout, RESP load response regs.
module mem_port_arbiter
  import mem_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int AW      = 32,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ-1:0]      req_write,
  input  logic [3*NREQ-1:0]    req_op,
  input  logic [AW*NREQ-1:0]   req_addr,
  input  logic [32*NREQ-1:0]   req_wdata,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [31:0]          rsp_data,
  output logic                 rsp_err,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic [AW-1:0]        mem_address,
  output logic [31:0]          mem_wdata,
  output logic [3:0]           mem_wstrb,
  input  logic                 mem_ack,
  input  logic [31:0]          mem_Message
);

  localparam int              IW       = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [IW-1:0]   LAST_IDX = IW'(NREQ - 1);
  localparam logic [7:0]      TO_LAST  = 8'(TIMEOUT - 1);

  state_t          r_state;
  logic [IW-1:0]   r_ptr;
  logic [7:0]      r_cnt;
  logic [NREQ-1:0] r_gnt;
  logic            r_write;
  logic [2:0]      r_op;
  logic [1:0]      r_lane;
  logic            r_err;
  logic [31:0]     r_rdata;
  logic            r_mem_read;
  logic            r_mem_write;
  logic [AW-1:0]   r_mem_address;
  logic [31:0]     r_mem_wdata;
  logic [3:0]      r_mem_wstrb;
  logic [NREQ-1:0] r_rsp_valid;
  logic [31:0]     r_rsp_data;
  logic            r_rsp_err;

  logic [NREQ-1:0] w_grant;
  logic [IW-1:0]   w_idx;
  logic            w_any;
  logic [2:0]      w_op;
  logic [AW-1:0]   w_addr;
  logic [31:0]     w_wdata;
  logic            w_write;
  logic            w_bad;

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rr (
    .i_valid (req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  assign w_op    = req_op[3*w_idx +: 3];
  assign w_addr  = req_addr[AW*w_idx +: AW];
  assign w_wdata = req_wdata[32*w_idx +: 32];
  assign w_write = req_write[w_idx];
  assign w_bad   = access_bad(w_write, w_op, w_addr[1:0]);

  // Grant is a same-cycle accept so the requester can drop valid on the next edge.
  assign req_ready   = (r_state == S_IDLE && !rst) ? w_grant : '0;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_data    = r_rsp_data;
  assign rsp_err     = r_rsp_err;
  assign mem_read    = r_mem_read;
  assign mem_write   = r_mem_write;
  assign mem_address = r_mem_address;
  assign mem_wdata   = r_mem_wdata;
  assign mem_wstrb   = r_mem_wstrb;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_ptr         <= '0;
      r_cnt         <= '0;
      r_gnt         <= '0;
      r_write       <= 1'b0;
      r_op          <= '0;
      r_lane        <= '0;
      r_err         <= 1'b0;
      r_rdata       <= '0;
      r_mem_read    <= 1'b0;
      r_mem_write   <= 1'b0;
      r_mem_address <= '0;
      r_mem_wdata   <= '0;
      r_mem_wstrb   <= '0;
      r_rsp_valid   <= '0;
      r_rsp_data    <= '0;
      r_rsp_err     <= 1'b0;
    end else begin
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_gnt   <= w_grant;
            r_write <= w_write;
            r_op    <= w_op;
            r_lane  <= w_addr[1:0];
            r_ptr   <= (w_idx == LAST_IDX) ? '0 : w_idx + 1'b1;
            r_cnt   <= '0;
            r_rdata <= '0;
            if (w_bad) begin
              r_err   <= 1'b1;
              r_state <= S_RESP;
            end else begin
              r_err         <= 1'b0;
              r_state       <= S_ISSUE;
              r_mem_read    <= !w_write;
              r_mem_write   <= w_write;
              r_mem_address <= {w_addr[AW-1:2], 2'b00};
              r_mem_wdata   <= w_write ? store_data(w_op[1:0], w_wdata) : '0;
              r_mem_wstrb   <= w_write ? store_strb(w_op[1:0], w_addr[1:0]) : '0;
            end
          end
        end
        S_ISSUE: begin
          if (mem_ack || r_cnt == TO_LAST) begin
            r_rdata       <= mem_ack ? mem_Message : '0;
            r_err         <= !mem_ack;
            r_mem_read    <= 1'b0;
            r_mem_write   <= 1'b0;
            r_mem_address <= '0;
            r_mem_wdata   <= '0;
            r_mem_wstrb   <= '0;
            r_state       <= S_RESP;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_RESP: begin
          r_rsp_valid <= r_gnt;
          r_rsp_data  <= (r_err || r_write) ? '0 : load_extract(r_op, r_lane, r_rdata);
          r_rsp_err   <= r_err;
          r_cnt       <= '0;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a response scoreboard.
module tb_mem_port_arbiter;

  localparam int NREQ = 4;
  localparam int AW   = 32;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NREQ-1:0]      req_valid, req_ready, req_write, rsp_valid;
  logic [3*NREQ-1:0]    req_op;
  logic [AW*NREQ-1:0]   req_addr;
  logic [32*NREQ-1:0]   req_wdata;
  logic [31:0]          rsp_data;
  logic                 rsp_err;
  logic                 mem_read, mem_write;
  logic [AW-1:0]        mem_address;
  logic [31:0]          mem_wdata;
  logic [3:0]           mem_wstrb;
  logic                 mem_ack;
  logic [31:0]          mem_Message;

  mem_port_arbiter #(.NREQ(NREQ), .AW(AW), .TIMEOUT(255)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ack(mem_ack), .mem_Message(mem_Message)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One request from requester idx; memory acks after ack_dly extra ISSUE cycles (-1: never).
  task automatic access(input int idx, input logic wr, input logic [2:0] op,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int ack_dly, input logic [31:0] msg, input logic exp_mem,
                        input logic [31:0] e_maddr, input logic [31:0] e_mwdata,
                        input logic [3:0] e_mstrb, input logic [31:0] e_data,
                        input logic e_err, input int e_lat,
                        input logic [NREQ-1:0] also_valid, output int waited);
    exp_t            e;
    int              n;
    bit              done;
    bit              unstable;
    logic [NREQ-1:0] onehot;
    onehot      = '0;
    onehot[idx] = 1'b1;
    n = 0; done = 0; unstable = 0; waited = 0;
    sb.push_back('{idx, e_data, e_err});
    @(negedge clk);
    req_write[idx]           = wr;
    req_op[3*idx +: 3]       = op;
    req_addr[AW*idx +: AW]   = addr;
    req_wdata[32*idx +: 32]  = wdata;
    req_valid                = req_valid | onehot | also_valid;
    #1;
    while (!req_ready[idx] && waited < 50) begin
      @(negedge clk);
      #1;
      waited++;
    end
    chk($sformatf("grant_r%0d", idx), req_ready, onehot);
    for (int k = 1; k <= 400 && !done; k++) begin
      @(negedge clk);
      req_valid = req_valid & ~(onehot | also_valid);
      if (rsp_valid !== '0) begin
        chk("rsp_sb_nonempty", sb.size(), 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk($sformatf("rsp_valid_r%0d", e.idx), rsp_valid, onehot);
          chk($sformatf("rsp_data_r%0d", e.idx), rsp_data, e.data);
          chk($sformatf("rsp_err_r%0d", e.idx), rsp_err, e.err);
        end
        if (e_lat >= 0) chk("rsp_latency", k, e_lat);
        done    = 1;
        mem_ack = 1'b0;
      end else if (mem_read || mem_write) begin
        if (n == 0) begin
          chk("mem_dir", {mem_read, mem_write}, {!wr, wr});
          chk("mem_address", mem_address, e_maddr);
          if (wr) begin
            chk("mem_wdata", mem_wdata, e_mwdata);
            chk("mem_wstrb", mem_wstrb, e_mstrb);
          end
        end else if (mem_address !== e_maddr || {mem_read, mem_write} !== {!wr, wr} ||
                     (wr && (mem_wdata !== e_mwdata || mem_wstrb !== e_mstrb))) begin
          unstable = 1;
        end
        n++;
        mem_ack     = (ack_dly >= 0 && n - 1 == ack_dly);
        mem_Message = mem_ack ? msg : $urandom();
      end else begin
        mem_ack = 1'b0;
      end
    end
    chk("rsp_seen", done, 1);
    chk("strobe_cycles", n, exp_mem ? ((ack_dly >= 0) ? ack_dly + 1 : 255) : 0);
    if (exp_mem) chk("strobe_stable", unstable, 0);
  endtask

  initial begin
    int              w;
    int              order[$];
    int              grants, rsps, nonhot, stray, cur;
    exp_t            e;
    logic [NREQ-1:0] oh;
    int              exp_order[5];
    exp_order = '{0, 1, 2, 3, 0};

    req_valid = '0; req_write = '0; req_op = '0; req_addr = '0; req_wdata = '0;
    mem_ack = 1'b0; mem_Message = '0;
    rst = 1'b1;

    for (int i = 0; i < NREQ; i++) begin
      req_op[3*i +: 3]     = mem_pkg::OP_LW;
      req_addr[AW*i +: AW] = 32'h100 * i;
    end
    req_valid = '1;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_ctl", {req_ready, rsp_valid, rsp_err, mem_read, mem_write, mem_wstrb}, 0);
    chk("reset_bus", {rsp_data, mem_address}, 0);
    chk("reset_wdata", mem_wdata, 0);
    @(negedge clk);
    rst = 1'b0;

    // all requesters valid from reset: expect grants 0,1,2,3,0
    grants = 0; rsps = 0; nonhot = 0; cur = 0;
    for (int k = 0; k < 100 && rsps < 5; k++) begin
      if (rsp_valid !== '0) begin
        chk("rr_sb_nonempty", sb.size(), 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          oh = '0;
          oh[e.idx] = 1'b1;
          chk("rr_rsp_valid", rsp_valid, oh);
          chk("rr_rsp_data", rsp_data, e.data);
        end
        rsps++;
      end
      mem_ack     = mem_read | mem_write;
      mem_Message = 32'hC0DE0000 | cur;
      if (grants >= 5) req_valid = '0;
      #1;
      if (req_ready !== '0 && grants < 5) begin
        if (!$onehot(req_ready)) nonhot++;
        for (int i = 0; i < NREQ; i++) begin
          if (req_ready[i]) begin
            cur = i;
            break;
          end
        end
        order.push_back(cur);
        sb.push_back('{cur, 32'hC0DE0000 | cur, 1'b0});
        grants++;
      end
      @(negedge clk);
    end
    mem_ack = 1'b0;
    chk("rr_grant_count", order.size(), 5);
    for (int i = 0; i < order.size() && i < 5; i++)
      chk($sformatf("rr_order_%0d", i), order[i], exp_order[i]);
    chk("rr_onehot", nonhot, 0);
    chk("rr_rsps", rsps, 5);

    // acks while idle must not produce anything
    stray = 0;
    mem_ack = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid !== '0 || mem_read || mem_write) stray++;
    end
    mem_ack = 1'b0;
    chk("stray_idle", stray, 0);

    // loads
    access(0, 0, mem_pkg::OP_LB,  32'h1003, 0, 0, 32'h80000000, 1, 32'h1000, 0, 0, 32'hFFFFFF80, 0, 3, '0, w);
    access(1, 0, mem_pkg::OP_LHU, 32'h2002, 0, 0, 32'hBEEF1234, 1, 32'h2000, 0, 0, 32'h0000BEEF, 0, 3, '0, w);
    access(2, 0, mem_pkg::OP_LH,  32'h2002, 0, 1, 32'hBEEF1234, 1, 32'h2000, 0, 0, 32'hFFFFBEEF, 0, 4, '0, w);
    access(3, 0, mem_pkg::OP_LBU, 32'h1001, 0, 0, 32'h12345678, 1, 32'h1000, 0, 0, 32'h00000056, 0, 3, '0, w);
    access(0, 0, mem_pkg::OP_LW,  32'h1004, 0, 2, 32'hCAFEF00D, 1, 32'h1004, 0, 0, 32'hCAFEF00D, 0, 5, '0, w);

    // stores
    access(1, 1, 3'b000, 32'h11, 32'h000000A5, 5, 0, 1, 32'h10, 32'hA5A5A5A5, 4'b0010, 0, 0, 8, '0, w);
    access(2, 1, 3'b001, 32'h22, 32'h1234BEEF, 0, 0, 1, 32'h20, 32'hBEEFBEEF, 4'b1100, 0, 0, 3, '0, w);
    access(3, 1, 3'b010, 32'h30, 32'hDEADBEEF, 0, 0, 1, 32'h30, 32'hDEADBEEF, 4'b1111, 0, 0, 3, '0, w);

    // rejected without memory access
    access(0, 0, mem_pkg::OP_LW, 32'h6, 0, -1, 0, 0, 0, 0, 0, 0, 1, 2, '0, w);
    access(1, 0, mem_pkg::OP_LH, 32'h3, 0, -1, 0, 0, 0, 0, 0, 0, 1, 2, '0, w);
    access(2, 0, 3'b011,         32'h0, 0, -1, 0, 0, 0, 0, 0, 0, 1, 2, '0, w);

    // timeout, then a late ack
    access(3, 0, mem_pkg::OP_LW, 32'h40, 0, -1, 0, 1, 32'h40, 0, 0, 0, 1, 257, '0, w);
    stray = 0;
    mem_ack = 1'b1;
    mem_Message = 32'h11111111;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid !== '0 || mem_read || mem_write) stray++;
    end
    mem_ack = 1'b0;
    chk("late_ack_ignored", stray, 0);

    // reset during the second ISSUE cycle
    @(negedge clk);
    req_write[2] = 1'b0;
    req_op[6 +: 3] = mem_pkg::OP_LW;
    req_addr[64 +: 32] = 32'h80;
    req_valid[2] = 1'b1;
    #1;
    chk("rst_grant", req_ready, 4'b0100);
    @(negedge clk);
    req_valid[2] = 1'b0;
    chk("rst_issue1", mem_read, 1);
    @(negedge clk);
    chk("rst_issue2", mem_read, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_strobe_off", {mem_read, mem_write}, 0);
    rst = 1'b0;
    stray = 0;
    repeat (5) begin
      @(negedge clk);
      if (rsp_valid !== '0) stray++;
    end
    chk("rst_no_rsp", stray, 0);
    access(0, 0, mem_pkg::OP_LW, 32'h50, 0, 0, 32'h0BADF00D, 1, 32'h50, 0, 0, 32'h0BADF00D, 0, 3, 4'b1000, w);
    chk("rst_ptr_first_try", w, 0);

    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single tile memory port between NREQ requesters: the tile controller load/store path, the message unit and up to two neighbour tiles.
- Arbitration is round-robin. Each access is sequenced over the mem_read/mem_write/mem_ack handshake.
- For loads, the block performs byte-lane extraction and sign/zero extension. For stores, it performs lane replication and strobe generation.
- It returns one response per accepted request, and sits between the controller and the memory interface.

Parameters:
- NREQ, 4, number of requesters (2..8)
- AW, 32, address width
- TIMEOUT, 255, ISSUE cycles without mem_ack before an error response (8-bit counter)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  one-hot grant/accept pulse
- req_write  in  NREQ  1=store, 0=load
- req_op  in  3*NREQ  per requester: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; stores use bits[1:0] as size
- req_addr  in  AW*NREQ  byte address
- req_wdata  in  32*NREQ  store data, right-aligned
- rsp_valid  out  NREQ  one-hot, one-cycle response pulse to the granted requester
- rsp_data  out  32  load result, 0 for stores and errors
- rsp_err  out  1  misaligned access or timeout, qualified by rsp_valid
- mem_read  out  1  load strobe, held until ack
- mem_write  out  1  store strobe, held until ack
- mem_address  out  AW  word-aligned address ({addr[AW-1:2],2'b00})
- mem_wdata  out  32  lane-replicated store data
- mem_wstrb  out  4  byte enables
- mem_ack  in  1  memory completion, level-sampled
- mem_Message  in  32  load return data, valid when mem_ack=1

Behaviour:
- Reset values: all outputs 0; state IDLE; round-robin pointer 0; timeout counter 0.
- States are IDLE, ISSUE and RESP.
- IDLE:
  - If any req_valid is set, grant the first valid requester at or after the pointer (cyclic search).
  - Pulse req_ready[g] this cycle, and latch op, addr, wdata and write.
  - Set pointer = (g+1) mod NREQ.
  - If aligned, next state is ISSUE; if misaligned, next state is RESP with err=1.
  - Misaligned means: lh/lhu/sh with addr[0]=1, or lw/sw with addr[1:0]!=0. Misaligned requests never touch memory.
- ISSUE:
  - mem_read or mem_write is 1 from the first ISSUE cycle. Address, wdata and wstrb are stable while the strobe is high.
  - On a cycle with mem_ack=1: capture mem_Message, deassert the strobe at the next edge, go to RESP.
  - Otherwise increment the counter. When the counter reaches TIMEOUT, deassert the strobe, go to RESP with err=1 and data 0.
- RESP:
  - Assert rsp_valid[g] for exactly one cycle, with rsp_data/rsp_err valid.
  - Go to IDLE. No grant occurs in the RESP cycle.
  - Minimum latency is grant→rsp_valid = 3 cycles when the ack arrives in the first ISSUE cycle.
- Load extraction: lane = addr[1:0], little-endian.
  - lb: byte sign-extended, with upper bits all ones when bit7=1.
  - lbu: zero-extended byte.
  - lh/lhu: halfword at addr[1]; sign-extended for lh, zero-extended for lhu.
  - lw: full word.
- Store generation:
  - Size 00 (byte): wdata replicated to all 4 bytes, wstrb = 1<<addr[1:0].
  - Size 01 (halfword): wdata replicated to both halves, wstrb = 0011 or 1100 by addr[1].
  - Size 10 (word): wstrb = 1111.
- Stray acks: mem_ack in IDLE or RESP is ignored and no response is generated. A late ack after a timeout is ignored.
- Requester behaviour: a requester holds req_valid and fields stable until req_ready. Dropping req_valid before grant is legal; the request is not captured.
- Simultaneous req_valid from all requesters are served in pointer order with no starvation. Worst case wait is (NREQ-1) accesses.
- Reset mid-operation: strobes are 0 at the edge after rst is sampled high, and no response is issued. The pointer returns to 0.
- Unsupported req_op values (011, 110, 111) on a load are treated as an error and return in RESP with err=1, with no memory access.

Decomposition:
- Shared package mem_pkg holds:
  - op encodings (OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU)
  - state enum
  - TIMEOUT default
  - functions for lane extraction and strobe generation
- One sub-module is natural: rr_arbiter, which takes the valid vector and pointer and outputs a one-hot grant and the grant index. It is purely combinational; the pointer register stays in the parent.

Test Plan:
- Single lb, requester 0: addr=0x1003, mem_Message=0x80_00_00_00, ack on the first ISSUE cycle → rsp_valid[0] 3 cycles after grant, rsp_data=0xFFFFFF80, err=0.
- lhu/lh: addr=0x2002, mem_Message=0xBEEF1234 → lhu returns 0x0000BEEF and lh returns 0xFFFFBEEF.
- Store: sb with wdata=0xA5 to addr=0x11 → mem_write=1, mem_address=0x10, mem_wdata=0xA5A5A5A5, mem_wstrb=0010. The strobe stays held for a 5-cycle ack delay.
- All four requesters valid continuously from reset → grant order 0,1,2,3,0. req_ready is one-hot and never coincides with RESP.
- lw to addr=0x6 → no mem_read, rsp_err=1, rsp_data=0. A separately issued load with no ack for 255 ISSUE cycles → err=1, strobe drops, and a later ack is ignored.
- rst asserted in the 2nd ISSUE cycle → mem_read=0 next cycle, no rsp_valid, and the next grant goes to requester 0.
